cp_output_stream_buffer: RTL and testbench

- Downstream neighbour of a CGRA application top. Consumes its valid-only output pixel stream (`<app>_update_0_write_valid` / `_write`) and buffers it in a small FIFO.
- Tags each pixel with an end-of-frame marker and re-emits it on a ready/valid interface toward the host/GLB drain path.
- The app stream has no backpressure, so the block detects and flags overflow instead of stalling.

---
 rtl/cp_stream_pkg.sv | 20 ++
 rtl/cp_sync_fifo.sv | 73 +++++++
 rtl/cp_output_stream_buffer.sv | 91 +++++++++
 tb/tb_cp_output_stream_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cp_stream_pkg.sv
// rtl/cp_stream_pkg.sv - shared types and defaults for the output stream buffer
package cp_stream_pkg;

  localparam int CP_DATA_WIDTH   = 16;
  localparam int CP_DEPTH        = 8;
  localparam int CP_FRAME_PIXELS = 64;

  typedef logic [CP_DATA_WIDTH-1:0] cp_pixel_t;

  typedef struct packed {
    logic      last;
    cp_pixel_t data;
  } cp_entry_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cp_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cp_sync_fifo.sv
// rtl/cp_sync_fifo.sv - first-word fall-through FIFO with occupancy count
module cp_sync_fifo
  import cp_stream_pkg::*;
#(
  parameter int WIDTH = $bits(cp_entry_t),
  parameter int DEPTH = CP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = cp_clog2_min1(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;

  // Head is forced to zero while empty so a cleared FIFO presents no stale word.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    do_push  = push & ~flush & (~full | pop);
    do_pop   = pop & ~flush & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cp_output_stream_buffer.sv
// rtl/cp_output_stream_buffer.sv - buffers a valid-only pixel stream, tags frame ends, flags overflow
module cp_output_stream_buffer
  import cp_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = CP_DATA_WIDTH,
  parameter int DEPTH        = CP_DEPTH,
  parameter int FRAME_PIXELS = CP_FRAME_PIXELS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic                       frame_done,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int EW = DATA_WIDTH + 1;
  localparam int CW = cp_clog2_min1(FRAME_PIXELS);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;
  logic          fifo_empty, fifo_full;
  logic          push, pop, drop, is_last;
  logic [EW-1:0] wr_entry, rd_entry;

  cp_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign out_valid  = ~fifo_empty;
  assign out_data   = rd_entry[DATA_WIDTH-1:0];
  assign out_last   = rd_entry[EW-1];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  always_comb begin
    pop      = ~fifo_empty & out_ready & ~flush;
    push     = in_valid & ~flush & (~fifo_full | pop);
    drop     = in_valid & ~flush & fifo_full & ~pop;
    is_last  = (pix_cnt_q == LAST_IDX);
    wr_entry = {is_last, in_data};
  end

  // The pixel counter tracks offered pixels, not stored ones, so drops never shift frame alignment.
  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    if (flush) begin
      pix_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (in_valid) pix_cnt_d = is_last ? '0 : pix_cnt_q + CW'(1);
      overflow_d   = overflow_q | drop;
      frame_done_d = pop & rd_entry[EW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_cp_output_stream_buffer.sv
// tb/tb_cp_output_stream_buffer.sv - self-checking bench for cp_output_stream_buffer
module tb_cp_output_stream_buffer;

  localparam int DW = 16;
  localparam int DP = 8;
  localparam int FP = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, out_last, frame_done, overflow;
  logic [3:0]    level;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;

  logic [16:0] mq[$];
  int          m_pix;
  bit          m_ovf, m_fd;
  logic [16:0] got[$];
  logic [16:0] ex[$];

  cp_output_stream_buffer #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DP),
    .FRAME_PIXELS (FP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ent(input bit l, input int d);
    return {l, 16'(d)};
  endfunction

  // Reference: a plain queue of {last,data} plus a frame position counter over offered pixels.
  always @(posedge clk or negedge rst_n) begin
    bit pop_m, push_m;
    if (!rst_n) begin
      mq.delete(); m_pix = 0; m_ovf = 0; m_fd = 0;
    end else if (flush) begin
      mq.delete(); m_pix = 0; m_ovf = 0; m_fd = 0;
    end else begin
      m_fd   = 0;
      pop_m  = (mq.size() != 0) && out_ready;
      push_m = in_valid && ((mq.size() < DP) || pop_m);
      if (pop_m) begin
        m_fd = mq[0][16];
        void'(mq.pop_front());
      end
      if (in_valid && !push_m) m_ovf = 1;
      if (push_m) mq.push_back({(m_pix == FP-1), in_data});
      if (in_valid) m_pix = (m_pix + 1) % FP;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("level", 32'(level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      if (mq.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(mq[0][15:0]));
        chk("out_last", 32'(out_last), 32'(mq[0][16]));
      end
      if (out_valid && out_ready && !flush) got.push_back({out_last, out_data});
      if (frame_done) fd_cnt++;
    end
  end

  task automatic step(input bit iv, input int d, input bit rdy, input bit fl);
    in_valid  = iv;
    in_data   = 16'(d);
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_seq(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size() && i < got.size(); i++) chk(nm, 32'(got[i]), 32'(ex[i]));
    got.delete();
    ex.delete();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Asynchronous reset in the middle of a cycle with data buffered.
    for (int i = 0; i < 3; i++) step(1, 'h30 + i, 0, 0);
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    got.delete();

    // Pass-through with a ready consumer.
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) step(1, 'h10 + i, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) ex.push_back(ent(i == 3 || i == 7, 'h10 + i));
    cmp_seq("pass");
    chk("pass_frame_done_pulses", 32'(fd_cnt), 32'd2);

    // Full FIFO with simultaneous push and pop never drops.
    for (int i = 0; i < 8; i++) step(1, 'hF0 + i, 0, 0);
    chk("fullpp_level_pre", 32'(level), 32'd8);
    for (int i = 0; i < 5; i++) step(1, 'hF8 + i, 1, 0);
    chk("fullpp_level", 32'(level), 32'd8);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    repeat (12) step(0, 0, 1, 0);
    for (int i = 0; i < 13; i++) ex.push_back(ent(i == 3 || i == 7 || i == 11, 'hF0 + i));
    cmp_seq("fullpp");

    // Overflow: ten pixels into eight slots, frame position starts at 1 here.
    for (int i = 0; i < 10; i++) step(1, 'hA0 + i, 0, 0);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (10) step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) ex.push_back(ent(i == 2 || i == 6, 'hA0 + i));
    cmp_seq("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Flush at level 5 with frame position 2 while a pixel is offered.
    for (int i = 0; i < 7; i++) step(1, 'hB0 + i, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    chk("flush_pre_level", 32'(level), 32'd5);
    step(1, 'hEE, 1, 1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    got.delete();
    for (int i = 0; i < 4; i++) step(1, 'hE0 + i, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) ex.push_back(ent(i == 3, 'hE0 + i));
    cmp_seq("post_flush");

    // Frame alignment survives drops of the 2nd and 3rd pixel of a frame.
    for (int i = 0; i < 8; i++) step(1, 'hC0 + i, 0, 0);
    step(1, 'hD0, 1, 0);
    step(1, 'hD1, 0, 0);
    step(1, 'hD2, 0, 0);
    step(1, 'hD3, 1, 0);
    repeat (12) step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) ex.push_back(ent(i == 3 || i == 7, 'hC0 + i));
    ex.push_back(ent(0, 'hD0));
    ex.push_back(ent(1, 'hD3));
    cmp_seq("align");
    chk("align_overflow", 32'(overflow), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
